// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full-adder cell, LSB first, one bit per clock.
// Define TIME_REDUNDANCY_EN to add a second pass whose mismatch against the first raises err.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err
);

   localparam int unsigned   IW   = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

`ifdef TIME_REDUNDANCY_EN
   typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, PASS1, DONE} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] word_last;
`ifdef TIME_REDUNDANCY_EN
   logic             cin_q;
   logic [WIDTH-1:0] r1;
   logic             c1;
`endif

   // The last bit is captured at the same edge that leaves the pass, so fold it in here.
   assign word_last = {fa_s, shadow[WIDTH-2:0]};

   always_comb begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
      if (busy) begin
         fa_a   = a_q[idx];
         fa_b   = b_q[idx];
         fa_cin = carry_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         shadow  <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef TIME_REDUNDANCY_EN
         cin_q   <= 1'b0;
         r1      <= '0;
         c1      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  carry_q <= cin_in;
                  idx     <= '0;
                  err     <= 1'b0;
                  busy    <= 1'b1;
                  state   <= PASS1;
`ifdef TIME_REDUNDANCY_EN
                  cin_q   <= cin_in;
`endif
               end
            end
            PASS1: begin
               shadow[idx] <= fa_s;
               carry_q     <= fa_cout;
               idx         <= idx + 1'b1;
               if (idx == LAST) begin
                  idx <= '0;
`ifdef TIME_REDUNDANCY_EN
                  r1      <= word_last;
                  c1      <= fa_cout;
                  carry_q <= cin_q;
                  state   <= PASS2;
`else
                  sum   <= word_last;
                  cout  <= fa_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`endif
               end
            end
`ifdef TIME_REDUNDANCY_EN
            PASS2: begin
               shadow[idx] <= fa_s;
               carry_q     <= fa_cout;
               idx         <= idx + 1'b1;
               if (idx == LAST) begin
                  idx   <= '0;
                  sum   <= r1;
                  cout  <= c1;
                  err   <= ({fa_cout, word_last} != {c1, r1});
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial sequencer that time-shares a single external `fulladder` cell to add two WIDTH-bit operands, LSB first, one bit per clock. It sits between a word-level requester (start/done handshake) and the gate-level full-adder datapath under fault test. It owns the carry register and result shift-in. An optional second pass recomputes the sum and flags transient faults.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; must be at least 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a_in`  in  WIDTH  operand A; latched when start is accepted.
- `b_in`  in  WIDTH  operand B; latched when start is accepted.
- `cin_in`  in  1  carry-in; latched when start is accepted.
- `fa_a`  out  1  to fulladder `a`.
- `fa_b`  out  1  to fulladder `b`.
- `fa_cin`  out  1  to fulladder `cin`.
- `fa_s`  in  1  from fulladder `s`.
- `fa_cout`  in  1  from fulladder `cout`.
- `busy`  out  1  high in PASS1/PASS2.
- `done`  out  1  one-cycle completion pulse.
- `sum`  out  WIDTH  result; held until the next accepted start.
- `cout`  out  1  final carry; held like `sum`.
- `err`  out  1  redundancy mismatch; held like `sum`.

## Operation
- States: IDLE, PASS1, PASS2 (only when `TIME_REDUNDANCY_EN` is defined), DONE.
- IDLE with `start`=1 at an edge:
  - latch a_q, b_q and carry_q←cin_in;
  - idx←0;
  - clear `err`;
  - go to PASS1.
- PASS cycle, combinational drive from registers only: fa_a=a_q[idx], fa_b=b_q[idx], fa_cin=carry_q.
- PASS cycle, at the edge:
  - shadow[idx]←fa_s;
  - carry_q←fa_cout;
  - idx←idx+1.
- Leaving a pass happens at the edge where idx==WIDTH-1.
- PASS1 exit:
  - with redundancy: copy shadow/carry to first-result regs r1, c1; reload carry_q←latched cin; idx←0; go to PASS2.
  - without redundancy: sum←shadow; cout←fa_cout; go to DONE.
- PASS2 exit:
  - sum←r1; cout←c1;
  - err←({fa_cout, shadow with bit WIDTH-1 = fa_s} != {c1, r1});
  - go to DONE.
- DONE: `done`=1 for one cycle, then IDLE at the next edge.
- `start` in any state other than IDLE is ignored; it is not queued.
- fa_a, fa_b, fa_cin are 0 in IDLE and DONE.
- idx width is clog2(WIDTH). There is no wrap, because the exit condition fires at WIDTH-1.

## Timing
- Reset (synchronous, dominates `start`):
  - state IDLE;
  - busy, done, err, cout, fa_a, fa_b, fa_cin = 0;
  - sum = 0;
  - all internal registers = 0.
- Reset mid-pass aborts the operation. No `done` is produced and outputs go to reset values at that edge.
- Let E0 be the edge that accepts `start`.
- PASS1 bits are captured at edges E1..E_WIDTH.
- Without redundancy:
  - `done` is high in the cycle after E_WIDTH, which is WIDTH cycles of busy;
  - latency from start to done is WIDTH+1 cycles.
- With redundancy:
  - `done` follows E_2·WIDTH;
  - latency is 2·WIDTH+1 cycles.
- `sum`, `cout` and `err` update at the same edge that raises `done`.
- Earliest next accept is the edge that ends DONE, so back-to-back throughput is one add per WIDTH+2 cycles, or 2·WIDTH+2 with redundancy.
- The fulladder is combinational. The result must settle within one clock period of the fa_* drive changing.

## Configuration
- `TIME_REDUNDANCY_EN` defined:
  - PASS2 is present and every add is computed twice;
  - `err` reports any bit or carry mismatch between passes;
  - this detects transient faults only; a permanent stuck-at fault yields identical passes and err=0.
- `TIME_REDUNDANCY_EN` undefined:
  - PASS2 and r1/c1 are removed;
  - `err` is tied to 0;
  - latency is WIDTH+1.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0 → sum=0x8D, cout=0, err=0. `done` pulses 9 cycles after E0, or 17 with redundancy, and `busy` is high for 8 or 16 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- `start` pulsed every cycle during a pass with different operands → only the first request is processed. The second add begins only when `start` is seen in IDLE, and the held `sum` is unchanged until then.
- `rst` asserted at bit 4 of PASS1 → next cycle all outputs are 0 and there is no `done`. A following start with 0x01+0x01 → sum=0x02.
- Redundancy build: force fa_s=1 only during PASS2 bit 0, with operands 0x00+0x00 → sum=0x00, err=1. Force fa_s stuck-at-1 in both passes → sum=0xFF, err=0.
- Monitor on every cycle: fa_a, fa_b, fa_cin are 0 whenever `busy`=0, and `done` is never high for two consecutive cycles.
